// File: rtl/tlb_maint_seq_pkg.sv
// Shared types and constants for the TLB maintenance sequencer.
package tlb_maint_seq_pkg;

    localparam int unsigned NUM_ENTRIES = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned VPN2_W      = 19;
    localparam int unsigned VPN2_LO_W   = 16;  // VPN2 bits covered by PageMask
    localparam int unsigned ASID_W      = 8;
    localparam int unsigned MASK_W      = 16;
    localparam int unsigned PFN_W       = 20;
    localparam int unsigned CACHE_W     = 3;
    localparam int unsigned LO_W        = 26;

    // G sits in bit 0, so the stored (G-less) Lo field is simply Lo[LO_W-1:1].
    localparam int unsigned LO_G_BIT    = 0;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    // EntryLo layout, MSB first: {PFN, C, D, V, G}
    typedef struct packed {
        logic [PFN_W-1:0]   pfn;
        logic [CACHE_W-1:0] c;
        logic               d;
        logic               v;
        logic               g;
    } lo_t;

    typedef enum logic [1:0] {
        OpTlbr  = 2'b00,
        OpTlbwi = 2'b01,
        OpTlbwr = 2'b10,
        OpTlbp  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StWrite = 3'd2,
        StProbe = 3'd3,
        StDone  = 3'd4
    } state_e;

    // One TLB entry; the global bit is kept once, not per page.
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic [MASK_W-1:0] mask;
        logic              g;
        logic [LO_W-2:0]   lo0;
        logic [LO_W-2:0]   lo1;
    } tlb_entry_t;

    // Build a stored entry from the write operands: global only if both pages say so.
    function automatic tlb_entry_t pack_entry(
        input logic [VPN2_W-1:0] vpn2,
        input logic [ASID_W-1:0] asid,
        input logic [MASK_W-1:0] mask,
        input logic [LO_W-1:0]   lo0,
        input logic [LO_W-1:0]   lo1
    );
        tlb_entry_t e;
        lo_t        l0;
        lo_t        l1;
        l0     = lo0;
        l1     = lo1;
        e.vpn2 = vpn2;
        e.asid = asid;
        e.mask = mask;
        e.g    = l0.g & l1.g;
        e.lo0  = lo0[LO_W-1:LO_G_BIT+1];
        e.lo1  = lo1[LO_W-1:LO_G_BIT+1];
        return e;
    endfunction

    // Rebuild an EntryLo value for read-back with the shared global bit.
    function automatic logic [LO_W-1:0] unpack_lo(
        input logic [LO_W-2:0] lo,
        input logic            g
    );
        return {lo, g};
    endfunction

endpackage

// File: rtl/tlb_maint_seq_vpn_match.sv
// Combinational masked VPN2/ASID compare of one TLB entry against the probe key.
module tlb_vpn_match
    import tlb_maint_seq_pkg::*;
(
    input  logic [VPN2_W-1:0] i_e_vpn2,
    input  logic [ASID_W-1:0] i_e_asid,
    input  logic [MASK_W-1:0] i_e_mask,
    input  logic              i_e_g,
    input  logic [VPN2_W-1:0] i_hi_vpn2,
    input  logic [ASID_W-1:0] i_hi_asid,
    output logic              o_match
);

    logic w_lo_eq;
    logic w_hi_eq;
    logic w_asid_ok;

    // Masked low VPN2 bits, exact upper VPN2 bits, ASID unless global.
    always_comb begin
        w_lo_eq   = ((i_e_vpn2[VPN2_LO_W-1:0] & ~i_e_mask) ==
                     (i_hi_vpn2[VPN2_LO_W-1:0] & ~i_e_mask));
        w_hi_eq   = (i_e_vpn2[VPN2_W-1:VPN2_LO_W] == i_hi_vpn2[VPN2_W-1:VPN2_LO_W]);
        w_asid_ok = i_e_g | (i_e_asid == i_hi_asid);
        o_match   = w_lo_eq & w_hi_eq & w_asid_ok;
    end

endmodule

// File: rtl/tlb_maint_seq.sv
// TLB maintenance sequencer: TLBR / TLBWI / TLBWR / TLBP over a 16-entry TLB,
// with a free-running Random replacement index bounded below by Wired.
module tlb_maint_seq
    import tlb_maint_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              Cmd_Valid,
    input  logic [1:0]        Cmd_Op,
    output logic              Cmd_Ready,
    input  logic [IDX_W-1:0]  Index_In,
    input  logic [IDX_W-1:0]  Wired,
    input  logic [VPN2_W-1:0] Hi_VPN2,
    input  logic [ASID_W-1:0] Hi_ASID,
    input  logic [MASK_W-1:0] Mask_In,
    input  logic [LO_W-1:0]   Lo0_In,
    input  logic [LO_W-1:0]   Lo1_In,
    output logic              Done,
    output logic [VPN2_W-1:0] Rd_VPN2,
    output logic [ASID_W-1:0] Rd_ASID,
    output logic [MASK_W-1:0] Rd_Mask,
    output logic [LO_W-1:0]   Rd_Lo0,
    output logic [LO_W-1:0]   Rd_Lo1,
    output logic [IDX_W-1:0]  Probe_Index,
    output logic              Probe_Miss,
    output logic [IDX_W-1:0]  Random
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_accept;
    logic              w_match;
    logic              w_scan_last;

    // Command operands captured on accept
    logic [IDX_W-1:0]  r_index;
    logic [VPN2_W-1:0] r_vpn2;
    logic [ASID_W-1:0] r_asid;
    logic [MASK_W-1:0] r_mask;
    logic [LO_W-1:0]   r_lo0;
    logic [LO_W-1:0]   r_lo1;

    logic [IDX_W-1:0]  r_scan;
    logic [IDX_W-1:0]  r_random;
    logic [IDX_W-1:0]  w_random_nxt;

    tlb_entry_t        r_entries [NUM_ENTRIES];

    logic [VPN2_W-1:0] r_rd_vpn2;
    logic [ASID_W-1:0] r_rd_asid;
    logic [MASK_W-1:0] r_rd_mask;
    logic [LO_W-1:0]   r_rd_lo0;
    logic [LO_W-1:0]   r_rd_lo1;
    logic [IDX_W-1:0]  r_probe_index;
    logic              r_probe_miss;

    assign Cmd_Ready   = (r_state == StIdle);
    assign Done        = (r_state == StDone);
    assign Random      = r_random;
    assign Rd_VPN2     = r_rd_vpn2;
    assign Rd_ASID     = r_rd_asid;
    assign Rd_Mask     = r_rd_mask;
    assign Rd_Lo0      = r_rd_lo0;
    assign Rd_Lo1      = r_rd_lo1;
    assign Probe_Index = r_probe_index;
    assign Probe_Miss  = r_probe_miss;
    assign w_scan_last = (r_scan == LAST_IDX);

    // Single comparator, walked across the entries by the scan counter.
    tlb_vpn_match u_vpn_match (
        .i_e_vpn2  (r_entries[r_scan].vpn2),
        .i_e_asid  (r_entries[r_scan].asid),
        .i_e_mask  (r_entries[r_scan].mask),
        .i_e_g     (r_entries[r_scan].g),
        .i_hi_vpn2 (r_vpn2),
        .i_hi_asid (r_asid),
        .o_match   (w_match)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and accept decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (Cmd_Valid) begin
                    w_accept = 1'b1;
                    case (Cmd_Op)
                        OpTlbr:           w_state_nxt = StRead;
                        OpTlbwi, OpTlbwr: w_state_nxt = StWrite;
                        default:          w_state_nxt = StProbe;
                    endcase
                end
            end
            StRead, StWrite: w_state_nxt = StDone;
            StProbe: begin
                if (w_match || w_scan_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Capture command operands; TLBWR targets the Random value of the accept cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_index <= '0;
            r_vpn2  <= '0;
            r_asid  <= '0;
            r_mask  <= '0;
            r_lo0   <= '0;
            r_lo1   <= '0;
        end else if (w_accept) begin
            r_index <= (Cmd_Op == OpTlbwr) ? r_random : Index_In;
            r_vpn2  <= Hi_VPN2;
            r_asid  <= Hi_ASID;
            r_mask  <= Mask_In;
            r_lo0   <= Lo0_In;
            r_lo1   <= Lo1_In;
        end
    end

    // Probe scan counter: entry k is examined k cycles after entering PROBE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan <= '0;
        end else if (w_accept) begin
            r_scan <= '0;
        end else if (r_state == StProbe) begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // Entry array; only the WRITE state modifies it, so a reset can never leave a partial write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else if (r_state == StWrite) begin
            r_entries[r_index] <= pack_entry(r_vpn2, r_asid, r_mask, r_lo0, r_lo1);
        end
    end

    // TLBR result registers, loaded in READ and held until the next TLBR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_vpn2 <= '0;
            r_rd_asid <= '0;
            r_rd_mask <= '0;
            r_rd_lo0  <= '0;
            r_rd_lo1  <= '0;
        end else if (r_state == StRead) begin
            r_rd_vpn2 <= r_entries[r_index].vpn2;
            r_rd_asid <= r_entries[r_index].asid;
            r_rd_mask <= r_entries[r_index].mask;
            r_rd_lo0  <= unpack_lo(r_entries[r_index].lo0, r_entries[r_index].g);
            r_rd_lo1  <= unpack_lo(r_entries[r_index].lo1, r_entries[r_index].g);
        end
    end

    // TLBP result registers, updated only when a scan finishes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_probe_index <= '0;
            r_probe_miss  <= 1'b0;
        end else if (r_state == StProbe) begin
            if (w_match) begin
                r_probe_index <= r_scan;
                r_probe_miss  <= 1'b0;
            end else if (w_scan_last) begin
                r_probe_index <= '0;
                r_probe_miss  <= 1'b1;
            end
        end
    end

    // Random decrements each cycle and wraps to the top once it reaches Wired.
    always_comb begin
        w_random_nxt = r_random - 1'b1;
        if (r_random <= Wired) begin
            w_random_nxt = LAST_IDX;
        end
    end

    // Random register, free-running in every state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_random <= LAST_IDX;
        end else begin
            r_random <= w_random_nxt;
        end
    end

endmodule

// File: doc/tlb_maint_seq.md
TLB_MAINT_SEQ -- requirements
Module: tlb_maint_seq

Interface
REQ-001 SHALL: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: Cmd_Valid  input  1  command request.
REQ-004 SHALL: Cmd_Op  input  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
REQ-005 SHALL: Cmd_Ready  output  1  command accepted when Cmd_Valid & Cmd_Ready.
REQ-006 SHALL: Index_In  input  4  target entry for TLBR/TLBWI.
REQ-007 SHALL: Wired  input  4  lowest index that Random may take.
REQ-008 SHALL: Hi_VPN2  input  19  VA[31:13] for write/probe.
REQ-009 SHALL: Hi_ASID  input  8  ASID for write/probe.
REQ-010 SHALL: Mask_In  input  16  PageMask[28:13] for write.
REQ-011 SHALL: Lo0_In, Lo1_In  input  26 each  {PFN[19:0], C[2:0], D, V, G} for even/odd page.
REQ-012 SHALL: Done  output  1  one-cycle completion pulse.
REQ-013 SHALL: Rd_VPN2 (19), Rd_ASID (8), Rd_Mask (16), Rd_Lo0 (26), Rd_Lo1 (26)  outputs  TLBR result.
REQ-014 SHALL: Probe_Index  output  4; Probe_Miss  output  1  TLBP result.
REQ-015 SHALL: Random  output  4  current replacement index.

Function
REQ-016 SHALL: hold 16 entries {VPN2, ASID, Mask, G, Lo0 sans G, Lo1 sans G}; stored G = Lo0_In.G & Lo1_In.G; read-back Lo0.G = Lo1.G = stored G.
REQ-017 SHALL: FSM states IDLE, READ, WRITE, PROBE, DONE; Cmd_Ready = 1 only in IDLE; Cmd_Valid ignored elsewhere.
REQ-018 SHALL: on accept (cycle N) latch all command inputs, and for TLBWR latch Random as the target; IDLE→READ (00), WRITE (01/10), PROBE (11).
REQ-019 SHALL: READ/WRITE take one cycle (N+1), then DONE; Done = 1 in cycle N+2; DONE→IDLE next cycle; Cmd_Ready reasserts N+3.
REQ-020 SHALL: TLBR load Rd_* from entry Index_In in READ; Rd_* hold until next TLBR.
REQ-021 SHALL: TLBWI/TLBWR write the entry at end of WRITE; a command accepted at N+3 observes the new contents.
REQ-022 SHALL: PROBE scan entries 0..15, one per cycle, entry k compared in cycle N+1+k; first (lowest-index) match ends scan.
REQ-023 SHALL: match = ((E.VPN2[15:0] & ~E.Mask) == (Hi_VPN2[15:0] & ~E.Mask)) & (E.VPN2[18:16] == Hi_VPN2[18:16]) & (E.G | E.ASID == Hi_ASID); valid bits do not affect match.
REQ-024 SHALL: hit at k: Done at N+2+k, Probe_Index = k, Probe_Miss = 0; no hit: Done at N+17, Probe_Index = 0, Probe_Miss = 1; both hold until next TLBP.
REQ-025 SHALL: Random each cycle: next = (Random <= Wired) ? 15 : Random - 1; Wired = 15 pins Random at 15; runs in all states.

Reset
REQ-026 SHALL: reset forces IDLE, Cmd_Ready = 1 on deassertion, Done = 0, Random = 15, Probe_Index = 0, Probe_Miss = 0, Rd_* = 0.
REQ-027 SHALL: reset clear every entry to all-zero (V = 0, G = 0).
REQ-028 SHALL: reset mid-command abort it with no Done pulse and no partial entry write.

Structure
REQ-029 SHALL: shared package holds Cmd_Op encodings, FSM state encoding, NUM_ENTRIES = 16, entry field widths, Lo field bit positions.
REQ-030 SHALL: masked-compare of REQ-023 be sub-module tlb_vpn_match (combinational); instantiated once and driven by the scan counter.

Verification
REQ-031 SHALL: TLBWI Index 3, VPN2 0x00010, ASID 0x05, Mask 0, Lo0 G=1, Lo1 G=0; then TLBR 3 -> Rd_VPN2 0x00010, Rd_ASID 0x05, Rd_Lo0.G = Rd_Lo1.G = 0, Done at N+2.
REQ-032 SHALL: entry 7 VPN2 0x00123, Mask 0x0003, ASID 0x09, G=0; TLBP VPN2 0x00121 ASID 0x09 -> hit, Probe_Index 7, Done at N+9; ASID 0x0A -> Probe_Miss 1, Done at N+17.
REQ-033 SHALL: identical VPN2/ASID written to entries 2 and 9; TLBP -> Probe_Index 2, Done at N+4.
REQ-034 SHALL: Wired 12 from reset -> Random sequence 15,14,13,12,15; TLBWR accepted when Random = 13 writes entry 13.
REQ-035 SHALL: reset asserted at N+5 during TLBP -> no Done, Cmd_Ready 1 after release, all entries read back zero.
REQ-036 SHALL: Cmd_Valid held high while busy -> only one command accepted per Cmd_Ready window; Done exactly once per command.
